// File: rtl/sisc_ifetch_if.sv
// Instruction-memory bus between the SISC fetch stage (master) and instruction memory (slave).
// im_req is held high with a constant im_addr until im_ack; im_rdata is valid only in the im_ack cycle.
interface sisc_ifetch_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_rdata;
  logic          im_ack;

  modport master (output im_req, im_addr, input im_rdata, im_ack);
  modport slave  (input im_req, im_addr, output im_rdata, im_ack);
endinterface

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch stage: owns PC and IR, fetches over the im_req/im_ack bus.
// Optional fetch timeout enabled by defining SISC_IFETCH_TIMEOUT_EN.
module sisc_ifetch #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  sisc_ifetch_if.master im,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic          fetch_busy,
  output logic          ir_valid,
  output logic          fetch_err,
  output logic [1:0]    dbg_state
);

  if (AW < 16 || AW > 32 || DW != 32 || TIMEOUT < 1) begin : g_param_check
    $error("sisc_ifetch: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_abs;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_rdata_next;
  logic          r_ir_valid;
  logic          w_err_set;

  // Branch offset is sign-extended, absolute target zero-extended, both from instr[15:0].
  if (AW > 16) begin : g_ext
    assign w_off = {{(AW-16){r_instr[15]}}, r_instr[15:0]};
    assign w_abs = {{(AW-16){1'b0}}, r_instr[15:0]};
  end else begin : g_noext
    assign w_off = r_instr[15:0];
    assign w_abs = r_instr[15:0];
  end

`ifdef SISC_IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_timeout;

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_REQ) ? r_cnt + CW'(1) : '0;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign fetch_err = r_err;
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_rdata_next = r_rdata;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: if (ir_load) w_next = S_REQ;
      S_REQ: begin
        if (im.im_ack) begin
          w_rdata_next = im.im_rdata;
          w_next       = S_DONE;
        end
`ifdef SISC_IFETCH_TIMEOUT_EN
        else if (w_timeout) begin
          w_rdata_next = '0;
          w_err_set    = 1'b1;
          w_next       = S_DONE;
        end
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Fetched word is staged in r_rdata and committed to IR on leaving DONE.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_instr    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rdata    <= w_rdata_next;
      r_ir_valid <= (r_state == S_DONE);
      if (r_state == S_IDLE && ir_load) r_addr <= r_pc;
      if (r_state == S_DONE) r_instr <= r_rdata;
    end
  end

  // PC priority: clear, then update, else hold; targets use the IR value before any same-edge load.
  always_comb begin
    w_pc_next = r_pc;
    if (pc_rst) begin
      w_pc_next = '0;
    end else if (pc_write) begin
      if (!pc_sel)     w_pc_next = r_pc + AW'(1);
      else if (br_sel) w_pc_next = w_abs;
      else             w_pc_next = r_pc + w_off;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_pc <= '0;
    else        r_pc <= w_pc_next;
  end

  assign im.im_req  = (r_state == S_REQ);
  assign im.im_addr = r_addr;
  assign pc_out     = r_pc;
  assign instr      = r_instr;
  assign opcode     = r_instr[31:28];
  assign mm         = r_instr[27:24];
  assign fetch_busy = (r_state == S_REQ) || (r_state == S_DONE);
  assign ir_valid   = r_ir_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed bench for sisc_ifetch: transaction-level model of fetch timing and PC rules,
// a fetched-word scoreboard, and literal pins. Define SISC_IFETCH_TIMEOUT_EN for the timeout test.
module tb_sisc_ifetch;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, ir_load = 1'b0;
  logic [15:0] pc_out;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  logic        fetch_busy, ir_valid, fetch_err;
  logic [1:0]  dbg_state;

  sisc_ifetch_if #(.AW(16), .DW(32)) im_bus ();

  sisc_ifetch #(.AW(16), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .ir_load(ir_load), .im(im_bus.master), .pc_out(pc_out),
    .instr(instr), .opcode(opcode), .mm(mm), .fetch_busy(fetch_busy),
    .ir_valid(ir_valid), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0, valid_cnt = 0;
  // Fetch schedule in edge numbers: REQ during cycles m_load..m_req_end, IR commit at edge m_commit.
  int m_load = -100, m_req_end = -100, m_commit = -100, m_err_edge = -100;
  logic [31:0] m_data = '0;
  logic [15:0] exp_pc = '0, exp_addr = '0;
  logic [31:0] exp_instr = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: PC rules applied to the inputs seen at each edge; IR/err follow the fetch schedule.
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      exp_pc    = '0;
      exp_instr = '0;
      exp_err   = 1'b0;
    end else begin
      if (cyc + 1 == m_load) exp_addr = exp_pc;
      if (pc_rst)          exp_pc = 16'h0000;
      else if (pc_write) begin
        if (!pc_sel)       exp_pc = exp_pc + 16'd1;
        else if (br_sel)   exp_pc = exp_instr[15:0];
        else               exp_pc = exp_pc + exp_instr[15:0]; // sign extension is identity mod 2^16
      end
      if (cyc + 1 == m_commit)   exp_instr = m_data;
      if (cyc + 1 == m_err_edge) exp_err   = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic exp_req, exp_busy;
    exp_req  = (m_load > 0) && (cyc >= m_load) && (cyc <= m_req_end);
    exp_busy = (m_load > 0) && (cyc >= m_load) && (cyc <= m_req_end + 1);
    check("im_req", {31'b0, im_bus.im_req}, {31'b0, exp_req});
    if (exp_req) check("im_addr", {16'b0, im_bus.im_addr}, {16'b0, exp_addr});
    check("fetch_busy", {31'b0, fetch_busy}, {31'b0, exp_busy});
    check("ir_valid", {31'b0, ir_valid}, {31'b0, (m_load > 0) && (cyc == m_commit)});
    check("pc", {16'b0, pc_out}, {16'b0, exp_pc});
    check("instr", instr, exp_instr);
    check("opcode", {28'b0, opcode}, {28'b0, exp_instr[31:28]});
    check("mm", {28'b0, mm}, {28'b0, exp_instr[27:24]});
    check("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
    if (ir_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("sb_spurious_valid", 32'd1, 32'd0);
      else                   check("sb_word", instr, exp_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] data, input int waits, input bit no_ack);
    int n;
    @(posedge clk); #1;
    n          = cyc + 1;
    m_load     = n;
    m_req_end  = no_ack ? n + TMO - 1 : n + waits;
    m_commit   = m_req_end + 2;
    m_data     = no_ack ? 32'h0 : data;
    if (no_ack) m_err_edge = m_req_end + 1;
    exp_q.push_back(no_ack ? 32'h0 : data);
    ir_load = 1'b1;
    @(posedge clk); #1;
    ir_load = 1'b0;
    if (!no_ack) begin
      repeat (waits) begin @(posedge clk); #1; end
      im_bus.im_ack   = 1'b1;
      im_bus.im_rdata = data;
      @(posedge clk); #1;
      im_bus.im_ack   = 1'b0;
      im_bus.im_rdata = $urandom;
      repeat (2) begin @(posedge clk); #1; end
    end else begin
      while (cyc < m_commit + 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pc_op(input bit rst, input bit wr, input bit sel, input bit bsel);
    @(posedge clk); #1;
    pc_rst = rst; pc_write = wr; pc_sel = sel; br_sel = bsel;
    @(posedge clk); #1;
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  initial begin
    int exp_valids;
    im_bus.im_ack   = 1'b0;
    im_bus.im_rdata = $urandom;
    #1 rst_f = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_f = 1'b1;
    check("rst_pc", {16'b0, pc_out}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_req", {31'b0, im_bus.im_req}, 32'h0);

    // Zero-wait fetch
    fetch(32'h1234_0005, 0, 1'b0);
    check("t1_instr", instr, 32'h1234_0005);
    check("t1_opcode", {28'b0, opcode}, 32'h1);
    check("t1_mm", {28'b0, mm}, 32'h2);
    check("t1_valid_cnt", valid_cnt, 32'd1);

    // Three wait cycles, sequential PC step during REQ
    fork
      fetch(32'hA5C3_0001, 3, 1'b0);
      begin @(posedge clk); pc_op(1'b0, 1'b1, 1'b0, 1'b0); end
    join
    check("t2_pc", {16'b0, pc_out}, 32'h1);
    check("t2_instr", instr, 32'hA5C3_0001);

    // Relative and absolute branches
    pc_op(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 pc_write = 1'b1;
    repeat (16) @(posedge clk);
    #1 pc_write = 1'b0;
    check("t3_pc16", {16'b0, pc_out}, 32'h10);
    fetch(32'h3000_FFFC, 1, 1'b0);
    pc_op(1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_rel", {16'b0, pc_out}, 32'h000C);
    pc_op(1'b0, 1'b1, 1'b1, 1'b1);
    check("t3_abs", {16'b0, pc_out}, 32'hFFFC);
    fork
      fetch(32'h0000_0004, 0, 1'b0);
      begin repeat (2) @(posedge clk); pc_op(1'b0, 1'b1, 1'b1, 1'b0); end
    join
    check("t3_old_ir_target", {16'b0, pc_out}, 32'hFFF8);
    pc_op(1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_new_ir_target", {16'b0, pc_out}, 32'hFFFC);

    // Wrap and clear priority
    fetch(32'h0000_FFFF, 2, 1'b0);
    pc_op(1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_abs_ffff", {16'b0, pc_out}, 32'hFFFF);
    pc_op(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_wrap", {16'b0, pc_out}, 32'h0);
    pc_op(1'b0, 1'b1, 1'b0, 1'b0);
    pc_op(1'b1, 1'b1, 1'b1, 1'b1);
    check("t4_rst_wins", {16'b0, pc_out}, 32'h0);

    // Reset mid-REQ, then a late ack
    @(posedge clk); #1;
    m_load = cyc + 1; m_req_end = cyc + 1000; m_commit = -100;
    ir_load = 1'b1;
    @(posedge clk); #1 ir_load = 1'b0;
    @(posedge clk); #1;
    check("t5_req_before_rst", {31'b0, im_bus.im_req}, 32'h1);
    rst_f = 1'b0;
    m_load = -100; m_req_end = -100;
    #1 check("t5_req_in_rst", {31'b0, im_bus.im_req}, 32'h0);
    @(posedge clk); #1 rst_f = 1'b1;
    im_bus.im_ack = 1'b1; im_bus.im_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 im_bus.im_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_instr", instr, 32'h0);
    check("t5_busy", {31'b0, fetch_busy}, 32'h0);
    exp_valids = 5;

`ifdef SISC_IFETCH_TIMEOUT_EN
    fetch(32'h0, 0, 1'b1);
    check("t6_err", {31'b0, fetch_err}, 32'h1);
    check("t6_instr", instr, 32'h0);
    fetch(32'h7777_0001, 0, 1'b0);
    check("t6_err_sticky", {31'b0, fetch_err}, 32'h1);
    check("t6_instr_after", instr, 32'h7777_0001);
    exp_valids = 7;
`endif

    repeat (2) @(posedge clk);
    #1 check("total_valids", valid_cnt, exp_valids);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
